// File: rtl/hwpe_ctrl_ucode_loader.sv
// Microcode loader: unpacks a 32-bit config word stream into code words,
// loop descriptors and ranges, and presents them as flat vectors to the
// microcode sequencer once the whole program has been received and checked.
module hwpe_ctrl_ucode_loader #(
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 28,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned AW       = $clog2(NB_REG + NB_RO_REG),
  localparam int unsigned CODE_W   = 1 + 2 * AW
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [LENGTH*CODE_W-1:0]      code_o,
  output logic [NB_LOOPS*8-1:0]         loop_addr_o,
  output logic [NB_LOOPS*8-1:0]         loop_nops_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0] range_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic                          error_o
);

  localparam int unsigned CW_W = 8;
  localparam int unsigned LC_W = 4;

  if (CODE_W > 16) begin : g_code_w_chk
    $error("hwpe_ctrl_ucode_loader: CODE_W must not exceed 16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_CODE, S_LOOPS, S_CHECK, S_READY, S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic [CODE_W-1:0]    code_q  [LENGTH];
  logic [7:0]           addr_q  [NB_LOOPS];
  logic [7:0]           nops_q  [NB_LOOPS];
  logic [CNT_WIDTH-1:0] range_q [NB_LOOPS];

  logic [7:0]      nb_code_q;
  logic [LC_W-1:0] nb_loops_q;
  logic [CW_W-1:0] cw_q;
  logic [LC_W-1:0] lc_q;
  logic            bad_q;

  logic                 accept_c;
  logic                 hdr_ok_c;
  logic                 last_code_c;
  logic                 last_loop_c;
  logic                 loop_bad_c;
  logic [8:0]           nb_words_c;
  logic [7:0]           w_addr_c;
  logic [7:0]           w_nops_c;
  logic [CNT_WIDTH-1:0] w_range_c;

  // Stream handshake and decode of the word currently offered
  assign wready_o    = (state_q == S_HEADER) || (state_q == S_CODE) || (state_q == S_LOOPS);
  assign accept_c    = wvalid_i && wready_o && !start_i;
  assign hdr_ok_c    = (wdata_i[7:0] != 8'd0) && (wdata_i[7:0] <= 8'(LENGTH)) &&
                       (wdata_i[11:8] != 4'd0) && (wdata_i[11:8] <= 4'(NB_LOOPS));
  assign nb_words_c  = (9'(nb_code_q) + 9'd1) >> 1;
  assign last_code_c = (9'(cw_q) == (nb_words_c - 9'd1));
  assign last_loop_c = (lc_q == (nb_loops_q - 4'd1));
  assign w_addr_c    = wdata_i[7:0];
  assign w_nops_c    = wdata_i[15:8];
  assign w_range_c   = wdata_i[16 +: CNT_WIDTH];
  assign loop_bad_c  = (w_nops_c == 8'd0) || (w_range_c == '0) ||
                       ((9'(w_addr_c) + 9'(w_nops_c)) > 9'(nb_code_q));

  // Status decoded straight from the state register
  assign busy_o  = (state_q == S_HEADER) || (state_q == S_CODE) ||
                   (state_q == S_LOOPS)  || (state_q == S_CHECK);
  assign valid_o = (state_q == S_READY);
  assign error_o = (state_q == S_ERROR);

  // Flatten storage for the sequencer
  for (genvar i = 0; i < LENGTH; i++) begin : g_code_out
    assign code_o[i*CODE_W +: CODE_W] = code_q[i];
  end
  for (genvar j = 0; j < NB_LOOPS; j++) begin : g_loop_out
    assign loop_addr_o[j*8 +: 8]             = addr_q[j];
    assign loop_nops_o[j*8 +: 8]             = nops_q[j];
    assign range_o[j*CNT_WIDTH +: CNT_WIDTH] = range_q[j];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_i restarts the load from any state
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_HEADER;
    end else begin
      case (state_q)
        S_HEADER: if (accept_c) state_d = hdr_ok_c ? S_CODE : S_ERROR;
        S_CODE:   if (accept_c && last_code_c) state_d = S_LOOPS;
        S_LOOPS:  if (accept_c && last_loop_c) state_d = S_CHECK;
        S_CHECK:  state_d = bad_q ? S_ERROR : S_READY;
        default:  state_d = state_q;
      endcase
    end
  end

  // Counters, header fields and microcode storage
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      nb_code_q  <= '0;
      nb_loops_q <= '0;
      cw_q       <= '0;
      lc_q       <= '0;
      bad_q      <= 1'b0;
      for (int i = 0; i < LENGTH; i++) code_q[i] <= '0;
      for (int j = 0; j < NB_LOOPS; j++) begin
        addr_q[j]  <= '0;
        nops_q[j]  <= '0;
        range_q[j] <= '0;
      end
    end else if (start_i) begin
      cw_q  <= '0;
      lc_q  <= '0;
      bad_q <= 1'b0;
    end else begin
      case (state_q)
        S_HEADER: begin
          if (accept_c) begin
            nb_code_q  <= wdata_i[7:0];
            nb_loops_q <= wdata_i[11:8];
          end
        end
        S_CODE: begin
          if (accept_c) begin
            cw_q <= cw_q + 8'd1;
            // Two entries per word; entries past nb_code are zeroed
            for (int i = 0; i < LENGTH; i++) begin
              if (9'(i) == {cw_q, 1'b0}) begin
                code_q[i] <= (9'(i) < 9'(nb_code_q)) ? wdata_i[CODE_W-1:0] : '0;
              end
              if (9'(i) == {cw_q, 1'b1}) begin
                code_q[i] <= (9'(i) < 9'(nb_code_q)) ? wdata_i[16 +: CODE_W] : '0;
              end
            end
          end
        end
        S_LOOPS: begin
          if (accept_c) begin
            lc_q <= lc_q + 4'd1;
            if (loop_bad_c) bad_q <= 1'b1;
            for (int j = 0; j < NB_LOOPS; j++) begin
              if (LC_W'(j) == lc_q) begin
                addr_q[j]  <= w_addr_c;
                nops_q[j]  <= w_nops_c;
                range_q[j] <= w_range_c;
              end
            end
          end
        end
        S_CHECK: begin
          // Scrub stale entries and turn unused loops into single-pass no-ops
          for (int i = 0; i < LENGTH; i++) begin
            if (9'(i) >= 9'(nb_code_q)) code_q[i] <= '0;
          end
          for (int j = 0; j < NB_LOOPS; j++) begin
            if (LC_W'(j) >= nb_loops_q) begin
              addr_q[j]  <= 8'd0;
              nops_q[j]  <= 8'd1;
              range_q[j] <= CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_ucode_loader.sv
// Directed bench for the microcode loader.
module tb_hwpe_ctrl_ucode_loader;

  localparam int unsigned LENGTH    = 16;
  localparam int unsigned NB_LOOPS  = 6;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned CODE_W    = 11;

  logic                          clk_i = 1'b0;
  logic                          rst_i = 1'b1;
  logic                          clear_i = 1'b0;
  logic                          start_i = 1'b0;
  logic [31:0]                   wdata_i = '0;
  logic                          wvalid_i = 1'b0;
  logic                          wready_o;
  logic [LENGTH*CODE_W-1:0]      code_o;
  logic [NB_LOOPS*8-1:0]         loop_addr_o;
  logic [NB_LOOPS*8-1:0]         loop_nops_o;
  logic [NB_LOOPS*CNT_WIDTH-1:0] range_o;
  logic                          valid_o;
  logic                          busy_o;
  logic                          error_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [CODE_W-1:0]    exp_c [LENGTH];
  logic [7:0]           exp_a [NB_LOOPS];
  logic [7:0]           exp_n [NB_LOOPS];
  logic [CNT_WIDTH-1:0] exp_r [NB_LOOPS];

  hwpe_ctrl_ucode_loader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .wdata_i     (wdata_i),
    .wvalid_i    (wvalid_i),
    .wready_o    (wready_o),
    .code_o      (code_o),
    .loop_addr_o (loop_addr_o),
    .loop_nops_o (loop_nops_o),
    .range_o     (range_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LENGTH*CODE_W-1:0] pack_code();
    logic [LENGTH*CODE_W-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i*CODE_W +: CODE_W] = exp_c[i];
    return v;
  endfunction

  function automatic logic [NB_LOOPS*8-1:0] pack_addr();
    logic [NB_LOOPS*8-1:0] v;
    for (int j = 0; j < NB_LOOPS; j++) v[j*8 +: 8] = exp_a[j];
    return v;
  endfunction

  function automatic logic [NB_LOOPS*8-1:0] pack_nops();
    logic [NB_LOOPS*8-1:0] v;
    for (int j = 0; j < NB_LOOPS; j++) v[j*8 +: 8] = exp_n[j];
    return v;
  endfunction

  function automatic logic [NB_LOOPS*CNT_WIDTH-1:0] pack_range();
    logic [NB_LOOPS*CNT_WIDTH-1:0] v;
    for (int j = 0; j < NB_LOOPS; j++) v[j*CNT_WIDTH +: CNT_WIDTH] = exp_r[j];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Offer one word after an idle gap; returns 1 ns after the accepting edge
  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    wvalid_i = 1'b0;
    repeat (gap) tick();
    wdata_i  = w;
    wvalid_i = 1'b1;
    n = 0;
    while (!wready_o && n < 16) begin
      tick();
      n++;
    end
    if (!wready_o) begin
      n_total++;
      $display("FAIL send_timeout: wready_o=%0b after %0d cycles, required 1", wready_o, n);
    end
    tick();
    wvalid_i = 1'b0;
  endtask

  task automatic set_exp_t1();
    for (int i = 0; i < LENGTH; i++) exp_c[i] = '0;
    for (int j = 0; j < NB_LOOPS; j++) begin
      exp_a[j] = 8'd0; exp_n[j] = 8'd1; exp_r[j] = 16'd1;
    end
    exp_c[0] = 11'h123; exp_c[1] = 11'h456; exp_c[2] = 11'h789;
    exp_a[0] = 8'd0; exp_n[0] = 8'd2; exp_r[0] = 16'd4;
    exp_a[1] = 8'd2; exp_n[1] = 8'd1; exp_r[1] = 16'd3;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    n_total++;
    if ({valid_o, busy_o, error_o, wready_o} !== 4'b0000)
      $display("FAIL reset_status: got v/b/e/r=%b required 0000", {valid_o, busy_o, error_o, wready_o});
    else n_pass++;
    n_total++;
    if (code_o !== '0) $display("FAIL reset_code: got %h required 0", code_o);
    else n_pass++;
    n_total++;
    if ({loop_addr_o, loop_nops_o, range_o} !== '0)
      $display("FAIL reset_loops: got %h %h %h required 0", loop_addr_o, loop_nops_o, range_o);
    else n_pass++;
  endtask

  task automatic test_basic_load();
    pulse_start();
    n_total++;
    if ({busy_o, wready_o, valid_o} !== 3'b110)
      $display("FAIL t1_header_state: got b/r/v=%b required 110", {busy_o, wready_o, valid_o});
    else n_pass++;
    send_word(32'h0000_0203, 0);
    send_word(32'h0456_0123, 0);
    send_word(32'h07FF_0789, 0);
    send_word(32'h0004_0200, 0);
    send_word(32'h0003_0102, 0);
    n_total++;
    if ({valid_o, busy_o, wready_o} !== 3'b010)
      $display("FAIL t1_check_cycle: got v/b/r=%b required 010", {valid_o, busy_o, wready_o});
    else n_pass++;
    tick();
    set_exp_t1();
    n_total++;
    if ({valid_o, error_o, busy_o} !== 3'b100)
      $display("FAIL t1_valid: got v/e/b=%b required 100", {valid_o, error_o, busy_o});
    else n_pass++;
    n_total++;
    if (code_o[2*CODE_W +: CODE_W] !== 11'h789)
      $display("FAIL t1_code2: got %h required 789", code_o[2*CODE_W +: CODE_W]);
    else n_pass++;
    n_total++;
    if (code_o[3*CODE_W +: CODE_W] !== 11'h000)
      $display("FAIL t1_code3: got %h required 000", code_o[3*CODE_W +: CODE_W]);
    else n_pass++;
    n_total++;
    if (code_o !== pack_code()) $display("FAIL t1_code: got %h required %h", code_o, pack_code());
    else n_pass++;
    n_total++;
    if (loop_addr_o !== pack_addr()) $display("FAIL t1_addr: got %h required %h", loop_addr_o, pack_addr());
    else n_pass++;
    n_total++;
    if (loop_nops_o !== pack_nops()) $display("FAIL t1_nops: got %h required %h", loop_nops_o, pack_nops());
    else n_pass++;
    n_total++;
    if (range_o !== pack_range()) $display("FAIL t1_range: got %h required %h", range_o, pack_range());
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (valid_o !== 1'b1 || code_o !== pack_code())
      $display("FAIL t1_hold: got valid=%0b code=%h required 1 %h", valid_o, code_o, pack_code());
    else n_pass++;
  endtask

  task automatic test_bad_header();
    pulse_start();
    n_total++;
    if ({valid_o, busy_o} !== 2'b01)
      $display("FAIL t2_restart_from_ready: got v/b=%b required 01", {valid_o, busy_o});
    else n_pass++;
    send_word(32'h0000_0100, 0);
    n_total++;
    if ({error_o, valid_o, wready_o, busy_o} !== 4'b1000)
      $display("FAIL t2_nb_code0: got e/v/r/b=%b required 1000", {error_o, valid_o, wready_o, busy_o});
    else n_pass++;
    pulse_start();
    n_total++;
    if ({error_o, busy_o} !== 2'b01)
      $display("FAIL t2_error_cleared: got e/b=%b required 01", {error_o, busy_o});
    else n_pass++;
    send_word(32'h0000_0703, 0);
    n_total++;
    if ({error_o, valid_o, wready_o} !== 3'b100)
      $display("FAIL t2_nb_loops7: got e/v/r=%b required 100", {error_o, valid_o, wready_o});
    else n_pass++;
  endtask

  task automatic test_bad_loop();
    pulse_start();
    send_word(32'h0000_0104, 0);
    send_word(32'h0002_0001, 0);
    send_word(32'h0004_0003, 0);
    send_word(32'h0001_0302, 0);
    n_total++;
    if ({error_o, valid_o, busy_o} !== 3'b001)
      $display("FAIL t3_check_cycle: got e/v/b=%b required 001", {error_o, valid_o, busy_o});
    else n_pass++;
    tick();
    n_total++;
    if ({error_o, valid_o} !== 2'b10)
      $display("FAIL t3_loop_overrun: got e/v=%b required 10", {error_o, valid_o});
    else n_pass++;
  endtask

  task automatic test_abort_restart();
    pulse_start();
    send_word(32'h0000_0110, 0);
    send_word(32'h0101_0100, 0);
    send_word(32'h0103_0102, 0);
    send_word(32'h0105_0104, 0);
    send_word(32'h0107_0106, 0);
    pulse_start();
    n_total++;
    if ({valid_o, busy_o, wready_o} !== 3'b011)
      $display("FAIL t4_abort: got v/b/r=%b required 011", {valid_o, busy_o, wready_o});
    else n_pass++;
    // An illegal header offered together with start must be dropped
    start_i  = 1'b1;
    wvalid_i = 1'b1;
    wdata_i  = 32'h0000_0000;
    tick();
    start_i  = 1'b0;
    wvalid_i = 1'b0;
    n_total++;
    if ({error_o, wready_o} !== 2'b01)
      $display("FAIL t4_word_with_start: got e/r=%b required 01", {error_o, wready_o});
    else n_pass++;
    send_word(32'h0000_0305, 0);
    send_word(32'h0015_0014, 0);
    send_word(32'h0017_0016, 0);
    send_word(32'h07AB_0018, 0);
    send_word(32'h000A_0500, 0);
    send_word(32'h0001_0201, 0);
    send_word(32'hFFFF_0104, 0);
    tick();
    for (int i = 0; i < LENGTH; i++) exp_c[i] = '0;
    for (int j = 0; j < NB_LOOPS; j++) begin
      exp_a[j] = 8'd0; exp_n[j] = 8'd1; exp_r[j] = 16'd1;
    end
    exp_c[0] = 11'h014; exp_c[1] = 11'h015; exp_c[2] = 11'h016;
    exp_c[3] = 11'h017; exp_c[4] = 11'h018;
    exp_a[0] = 8'd0; exp_n[0] = 8'd5; exp_r[0] = 16'd10;
    exp_a[1] = 8'd1; exp_n[1] = 8'd2; exp_r[1] = 16'd1;
    exp_a[2] = 8'd4; exp_n[2] = 8'd1; exp_r[2] = 16'hFFFF;
    n_total++;
    if ({valid_o, error_o} !== 2'b10)
      $display("FAIL t4_valid: got v/e=%b required 10", {valid_o, error_o});
    else n_pass++;
    n_total++;
    if (code_o !== pack_code()) $display("FAIL t4_code: got %h required %h", code_o, pack_code());
    else n_pass++;
    n_total++;
    if ({loop_addr_o, loop_nops_o} !== {pack_addr(), pack_nops()})
      $display("FAIL t4_loops: got %h %h required %h %h", loop_addr_o, loop_nops_o, pack_addr(), pack_nops());
    else n_pass++;
    n_total++;
    if (range_o !== pack_range()) $display("FAIL t4_range: got %h required %h", range_o, pack_range());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    pulse_start();
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL t5_valid_drop: got %0b required 0", valid_o);
    else n_pass++;
    send_word(32'h0000_0203, int'($urandom_range(0, 3)));
    send_word(32'h0456_0123, int'($urandom_range(0, 3)));
    send_word(32'h07FF_0789, int'($urandom_range(0, 3)));
    send_word(32'h0004_0200, int'($urandom_range(0, 3)));
    send_word(32'h0003_0102, int'($urandom_range(1, 3)));
    tick();
    set_exp_t1();
    n_total++;
    if (valid_o !== 1'b1) $display("FAIL t5_valid: got %0b required 1", valid_o);
    else n_pass++;
    n_total++;
    if (code_o !== pack_code()) $display("FAIL t5_code: got %h required %h", code_o, pack_code());
    else n_pass++;
    n_total++;
    if ({loop_addr_o, loop_nops_o, range_o} !== {pack_addr(), pack_nops(), pack_range()})
      $display("FAIL t5_loops: got %h %h %h required %h %h %h", loop_addr_o, loop_nops_o, range_o,
               pack_addr(), pack_nops(), pack_range());
    else n_pass++;
  endtask

  task automatic test_clear_vs_start();
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    n_total++;
    if ({valid_o, busy_o, error_o, wready_o} !== 4'b0000)
      $display("FAIL t6_status: got v/b/e/r=%b required 0000", {valid_o, busy_o, error_o, wready_o});
    else n_pass++;
    n_total++;
    if ({code_o, loop_addr_o, loop_nops_o, range_o} !== '0)
      $display("FAIL t6_storage: got %h %h %h %h required 0", code_o, loop_addr_o, loop_nops_o, range_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_header();
    test_bad_loop();
    test_abort_restart();
    test_backpressure();
    test_clear_vs_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
